// File: rtl/prio_decode_fifo.sv
// prio_decode_fifo: small FIFO that buffers {any, idx} words coming out of a
// priority encoder and presents the head word downstream as a one-hot vector.
// The head is decoded from registered storage and pointers, so no input ever
// reaches an output combinationally.
module prio_decode_fifo #(
    parameter int IDX_W = 2,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IDX_W-1:0]             in_idx,
    input  logic                         in_any,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [(2**IDX_W)-1:0]        out_onehot,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int N     = 2**IDX_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

    // Each entry is {any, idx}; an any=0 entry is a real "no request" word.
    logic [IDX_W:0]     mem [DEPTH];
    logic [PTR_W-1:0]   wptr_reg;
    logic [PTR_W-1:0]   rptr_reg;
    logic [LVL_W-1:0]   level_reg;
    logic [LVL_W-1:0]   level_next;
    logic               push;
    logic               pop;
    logic [IDX_W:0]     head;

    assign in_ready  = (level_reg != FULL_LEVEL);
    assign out_valid = (level_reg != '0);
    assign level     = level_reg;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign head      = mem[rptr_reg];

    // Occupancy: simultaneous push and pop leave the count unchanged.
    always_comb begin
        level_next = level_reg;
        case ({push, pop})
            2'b10:   level_next = level_reg + LVL_W'(1);
            2'b01:   level_next = level_reg - LVL_W'(1);
            default: level_next = level_reg;
        endcase
    end

    // Pointer and occupancy state; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            level_reg <= '0;
        end else begin
            if (push) wptr_reg <= wptr_reg + PTR_W'(1);
            if (pop)  rptr_reg <= rptr_reg + PTR_W'(1);
            level_reg <= level_next;
        end
    end

    // Storage write; contents are not cleared by reset since level gates them.
    always_ff @(posedge clk) begin
        if (push) mem[wptr_reg] <= {in_any, in_idx};
    end

    // One-hot decode of the head word, forced to zero when empty or any=0.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_decode
            assign out_onehot[gi] = out_valid && head[IDX_W] &&
                                    (head[IDX_W-1:0] == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_prio_decode_fifo.sv
// Testbench for prio_decode_fifo: directed scenarios plus a randomized run,
// all checked against a queue-based model of the FIFO.
module tb_prio_decode_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] in_idx = 2'd0;
    logic       in_any = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_onehot;
    logic [2:0] level;

    int checks = 0;
    int errors = 0;

    // Model: queue of stored words, each {any, idx}.
    logic [2:0] q[$];

    prio_decode_fifo #(.IDX_W(2), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_idx(in_idx), .in_any(in_any),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_onehot(out_onehot), .level(level)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] exp_oh();
        logic [2:0] w;
        if (q.size() == 0) return 4'b0000;
        w = q[0];
        if (!w[2]) return 4'b0000;
        return 4'(1 << w[1:0]);
    endfunction

    // Advance one rising edge, updating the model from the handshake rules.
    task automatic cycle();
        bit do_push, do_pop;
        @(posedge clk);
        do_push = in_valid && (q.size() < 4) && rst_n;
        do_pop  = out_ready && (q.size() > 0) && rst_n;
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back({in_any, in_idx});
        #1;
    endtask

    task automatic push_word(input logic [1:0] idx, input logic any);
        in_valid = 1'b1; in_idx = idx; in_any = any;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;
        q.delete();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_onehot !== 4'b0000 || level !== 3'd0) begin
                errors++;
                $display("FAIL reset_idle cyc %0d got rdy=%b vld=%b oh=%b lvl=%0d want 1 0 0000 0",
                         i, in_ready, out_valid, out_onehot, level);
            end
            cycle();
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        push_word(2'd2, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_onehot !== 4'b0100) begin
            errors++;
            $display("FAIL single_decode got vld=%b oh=%b want 1 0100", out_valid, out_onehot);
        end
        cycle();
        checks++;
        if (out_valid !== 1'b0 || level !== 3'd0) begin
            errors++;
            $display("FAIL single_drain got vld=%b lvl=%0d want 0 0", out_valid, level);
        end
        out_ready = 1'b0;
        $display("test_single done");
    endtask

    task automatic test_fill_drain();
        logic [1:0] idxs [4] = '{2'd3, 2'd0, 2'd1, 2'd2};
        logic [3:0] exp  [4] = '{4'b1000, 4'b0001, 4'b0010, 4'b0100};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(idxs[i], 1'b1);
        checks++;
        if (level !== 3'd4 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full got lvl=%0d rdy=%b want 4 0", level, in_ready);
        end
        push_word(2'd1, 1'b1);
        checks++;
        if (level !== 3'd4 || out_onehot !== 4'b1000) begin
            errors++;
            $display("FAIL fill_reject got lvl=%0d oh=%b want 4 1000", level, out_onehot);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_onehot !== exp[i]) begin
                errors++;
                $display("FAIL drain_%0d got vld=%b oh=%b want 1 %b", i, out_valid, out_onehot, exp[i]);
            end
            cycle();
            if (i == 0) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL ready_after_pop got %b want 1", in_ready);
                end
            end
        end
        checks++;
        if (out_valid !== 1'b0 || level !== 3'd0) begin
            errors++;
            $display("FAIL drain_empty got vld=%b lvl=%0d want 0 0", out_valid, level);
        end
        out_ready = 1'b0;
        $display("test_fill_drain done");
    endtask

    task automatic test_empty_request();
        push_word(2'd3, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_onehot !== 4'b0000 || level !== 3'd1) begin
            errors++;
            $display("FAIL empty_req got vld=%b oh=%b lvl=%0d want 1 0000 1", out_valid, out_onehot, level);
        end
        out_ready = 1'b1;
        cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL empty_req_pop got vld=%b want 0", out_valid);
        end
        out_ready = 1'b0;
        $display("test_empty_request done");
    endtask

    task automatic test_back_to_back();
        push_word(2'd1, 1'b1);
        push_word(2'd3, 1'b1);
        checks++;
        if (level !== 3'd2 || out_onehot !== 4'b0010) begin
            errors++;
            $display("FAIL b2b_setup got lvl=%0d oh=%b want 2 0010", level, out_onehot);
        end
        in_valid = 1'b1; in_idx = 2'd0; in_any = 1'b1; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        checks++;
        if (level !== 3'd2 || out_onehot !== 4'b1000) begin
            errors++;
            $display("FAIL b2b_simul got lvl=%0d oh=%b want 2 1000", level, out_onehot);
        end
        cycle();
        checks++;
        if (out_onehot !== 4'b0001 || level !== 3'd1) begin
            errors++;
            $display("FAIL b2b_second got oh=%b lvl=%0d want 0001 1", out_onehot, level);
        end
        cycle();
        out_ready = 1'b0;
        $display("test_back_to_back done");
    endtask

    task automatic test_async_reset();
        push_word(2'd0, 1'b1);
        push_word(2'd2, 1'b1);
        push_word(2'd3, 1'b1);
        checks++;
        if (level !== 3'd3) begin
            errors++;
            $display("FAIL areset_setup got lvl=%0d want 3", level);
        end
        #2 rst_n = 1'b0;
        q.delete();
        #1;
        checks++;
        if (out_valid !== 1'b0 || level !== 3'd0 || in_ready !== 1'b1 || out_onehot !== 4'b0000) begin
            errors++;
            $display("FAIL areset_now got vld=%b lvl=%0d rdy=%b oh=%b want 0 0 1 0000",
                     out_valid, level, in_ready, out_onehot);
        end
        #1 rst_n = 1'b1;
        push_word(2'd1, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_onehot !== 4'b0010 || level !== 3'd1) begin
            errors++;
            $display("FAIL areset_next got vld=%b oh=%b lvl=%0d want 1 0010 1", out_valid, out_onehot, level);
        end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        $display("test_async_reset done");
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 45);
            in_idx    = 2'($urandom_range(0, 3));
            in_any    = ($urandom_range(0, 9) != 0);
            checks++;
            if (out_valid !== (q.size() != 0) || out_onehot !== exp_oh() ||
                level !== 3'(q.size()) || in_ready !== (q.size() < 4) || level > 3'd4) begin
                errors++;
                $display("FAIL random cyc %0d got vld=%b oh=%b lvl=%0d rdy=%b want %b %b %0d %b",
                         i, out_valid, out_onehot, level, in_ready,
                         (q.size() != 0), exp_oh(), q.size(), (q.size() < 4));
            end
            cycle();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_empty_request();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
